// File: rtl/enemy_spawner_if.sv
// Spawn request channel between the enemy spawner (master) and the enemy array (slave).
// Valid/ready handshake carrying the target slot index and the spawn pixel coordinates.
interface enemy_spawner_if #(
  parameter int NUM_SLOTS = 8
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic              spawn_valid;
  logic              spawn_ready;
  logic [SLOT_W-1:0] spawn_slot;
  logic [8:0]        spawn_x;
  logic [8:0]        spawn_y;

  modport master (
    output spawn_valid,
    output spawn_slot,
    output spawn_x,
    output spawn_y,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid,
    input  spawn_slot,
    input  spawn_x,
    input  spawn_y,
    output spawn_ready
  );
endinterface

// File: rtl/enemy_spawner.sv
// Enemy spawner: counts frame ticks per respawn interval, then requests a spawn into the
// lowest free enemy slot at a pseudo-random screen-edge point over a valid/ready channel.
module enemy_spawner #(
  parameter int         NUM_SLOTS = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_frame_tick,
  input  logic                 i_game_active,
  input  logic [9:0]           i_unit_time,
  input  logic [NUM_SLOTS-1:0] i_slot_alive,
  output logic [9:0]           o_spawn_count,
  enemy_spawner_if.master      spawn_bus
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    SEEK,
    ISSUE
  } state_t;

  state_t            r_state;
  logic [9:0]        r_counter;
  logic [9:0]        r_unit;
  logic [9:0]        r_spawn_count;
  logic [7:0]        r_lfsr;
  logic              r_valid;
  logic [SLOT_W-1:0] r_slot;
  logic [8:0]        r_x;
  logic [8:0]        r_y;
  logic [SLOT_W-1:0] r_pend_slot;
  logic [8:0]        r_pend_x;
  logic [8:0]        r_pend_y;

  logic              w_any_free;
  logic [SLOT_W-1:0] w_free_idx;
  logic [9:0]        w_unit_eff;
  logic [9:0]        w_count_next;
  logic [9:0]        w_count_sat;
  logic [8:0]        w_pt_x;
  logic [8:0]        w_pt_y;
  logic              w_handshake;
  logic              w_lfsr_fb;

  assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_unit_eff   = (i_unit_time == 10'd0) ? 10'd1 : i_unit_time;
  assign w_count_next = r_counter + 10'd1;
  assign w_count_sat  = (r_spawn_count == 10'h3FF) ? r_spawn_count : r_spawn_count + 10'd1;
  assign w_handshake  = r_valid & spawn_bus.spawn_ready;

  // Free-running LFSR; it keeps stepping in every state so spawn points depend on timing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end

  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!i_slot_alive[i]) begin
        w_any_free = 1'b1;
        w_free_idx = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    w_pt_x = 9'd8;
    w_pt_y = 9'd120;
    case (r_lfsr[1:0])
      2'd0: begin w_pt_x = 9'd8;   w_pt_y = 9'd120; end
      2'd1: begin w_pt_x = 9'd311; w_pt_y = 9'd120; end
      2'd2: begin w_pt_x = 9'd160; w_pt_y = 9'd8;   end
      default: begin w_pt_x = 9'd160; w_pt_y = 9'd231; end
    endcase
  end

  assign spawn_bus.spawn_valid = r_valid;
  assign spawn_bus.spawn_slot  = r_slot;
  assign spawn_bus.spawn_x     = r_x;
  assign spawn_bus.spawn_y     = r_y;
  assign o_spawn_count         = r_spawn_count;

  // SEEK captures the payload privately; ISSUE publishes it together with valid one edge later,
  // so the bus payload is zero whenever valid is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_counter     <= 10'd0;
      r_unit        <= 10'd1;
      r_spawn_count <= 10'd0;
      r_valid       <= 1'b0;
      r_slot        <= '0;
      r_x           <= 9'd0;
      r_y           <= 9'd0;
      r_pend_slot   <= '0;
      r_pend_x      <= 9'd0;
      r_pend_y      <= 9'd0;
    end else if (!i_game_active) begin
      if (w_handshake) begin
        r_spawn_count <= w_count_sat;
      end
      r_state   <= IDLE;
      r_counter <= 10'd0;
      r_valid   <= 1'b0;
      r_slot    <= '0;
      r_x       <= 9'd0;
      r_y       <= 9'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state   <= COUNT;
          r_counter <= 10'd0;
          r_unit    <= w_unit_eff;
        end
        COUNT: begin
          if (i_frame_tick) begin
            r_counter <= w_count_next;
            if (w_count_next >= r_unit) begin
              r_state <= SEEK;
            end
          end
        end
        SEEK: begin
          if (w_any_free) begin
            r_pend_slot <= w_free_idx;
            r_pend_x    <= w_pt_x;
            r_pend_y    <= w_pt_y;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_slot  <= r_pend_slot;
            r_x     <= r_pend_x;
            r_y     <= r_pend_y;
          end else if (spawn_bus.spawn_ready) begin
            r_spawn_count <= w_count_sat;
            r_valid       <= 1'b0;
            r_slot        <= '0;
            r_x           <= 9'd0;
            r_y           <= 9'd0;
            r_state       <= COUNT;
            r_counter     <= 10'd0;
            r_unit        <= w_unit_eff;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_enemy_spawner.sv
// Self-checking bench for enemy_spawner: table of spawn intervals plus hand-written corner cases,
// with a scoreboard of expected spawn requests (edge, slot, coordinates).
module tb_enemy_spawner;
  localparam int         NUM_SLOTS = 8;
  localparam logic [7:0] SEED      = 8'hA5;

  typedef struct {
    int slot;
    int x;
    int y;
    int riseEdge;
  } expT;

  typedef struct {
    int         unit;
    logic [7:0] alive;
    int         expSlot;
  } vecT;

  logic       clk = 1'b0;
  logic       rstN;
  logic       frameTick;
  logic       gameActive;
  logic [9:0] unitTime;
  logic [7:0] slotAlive;
  logic [9:0] spawnCount;
  logic [7:0] mLfsr;

  int  total;
  int  bad;
  int  edgeNum = 0;
  int  expCount;
  int  hitMask;
  int  cntBefore;
  bit  prevV;
  expT expQ[$];
  expT lastExp;
  vecT vecs[9];

  enemy_spawner_if #(.NUM_SLOTS(NUM_SLOTS)) bus ();

  enemy_spawner #(
    .NUM_SLOTS(NUM_SLOTS),
    .LFSR_SEED(SEED)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_frame_tick (frameTick),
    .i_game_active(gameActive),
    .i_unit_time  (unitTime),
    .i_slot_alive (slotAlive),
    .o_spawn_count(spawnCount),
    .spawn_bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeNum <= edgeNum + 1;

  function automatic logic [7:0] lfsrStep(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) mLfsr <= SEED;
    else       mLfsr <= lfsrStep(mLfsr);
  end

  // Accepted handshakes are counted just before the edge that takes them.
  always @(negedge clk) begin
    if (!rstN) expCount <= 0;
    else if (bus.spawn_valid && bus.spawn_ready && expCount < 1023) expCount <= expCount + 1;
  end

  function automatic int pointX(input logic [1:0] s);
    case (s)
      2'd0:    return 8;
      2'd1:    return 311;
      default: return 160;
    endcase
  endfunction

  function automatic int pointY(input logic [1:0] s);
    case (s)
      2'd2:    return 8;
      2'd3:    return 231;
      default: return 120;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input int slot, input logic [7:0] l, input int riseEdge);
    expT e;
    e.slot     = slot;
    e.x        = pointX(l[1:0]);
    e.y        = pointY(l[1:0]);
    e.riseEdge = riseEdge;
    expQ.push_back(e);
  endtask

  task automatic monitorStep();
    if (bus.spawn_valid && !prevV) begin
      if (bus.spawn_x == 9'd8   && bus.spawn_y == 9'd120) hitMask |= 1;
      if (bus.spawn_x == 9'd311 && bus.spawn_y == 9'd120) hitMask |= 2;
      if (bus.spawn_x == 9'd160 && bus.spawn_y == 9'd8)   hitMask |= 4;
      if (bus.spawn_x == 9'd160 && bus.spawn_y == 9'd231) hitMask |= 8;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedSpawn", 1, 0);
      end else begin
        lastExp = expQ.pop_front();
        checkOutput("riseEdge", edgeNum, lastExp.riseEdge);
        checkOutput("spawnSlot", int'(bus.spawn_slot), lastExp.slot);
        checkOutput("spawnX", int'(bus.spawn_x), lastExp.x);
        checkOutput("spawnY", int'(bus.spawn_y), lastExp.y);
      end
    end else if (bus.spawn_valid) begin
      checkOutput("holdSlot", int'(bus.spawn_slot), lastExp.slot);
      checkOutput("holdX", int'(bus.spawn_x), lastExp.x);
      checkOutput("holdY", int'(bus.spawn_y), lastExp.y);
    end else begin
      checkOutput("idlePayload", int'(bus.spawn_slot) + int'(bus.spawn_x) + int'(bus.spawn_y), 0);
    end
    prevV = bus.spawn_valid;
  endtask

  task automatic tickEdge();
    @(posedge clk);
    #1;
    monitorStep();
  endtask

  task automatic driveTick();
    tickEdge();
    frameTick = 1'b1;
    tickEdge();
    frameTick = 1'b0;
  endtask

  task automatic waitValid();
    for (int k = 0; k < 20 && !bus.spawn_valid; k++) tickEdge();
    checkOutput("spawnSeen", int'(bus.spawn_valid), 1);
  endtask

  // One full interval: drives the ticks, predicts the spawn from the terminal tick, waits for it.
  task automatic applyStimulus(input int ticks, input logic [7:0] alive, input int expSlot,
                               input int midAt, input int midUnit, input int nextUnit);
    slotAlive = alive;
    for (int t = 1; t <= ticks; t++) begin
      tickEdge();
      frameTick = 1'b1;
      if (t == ticks) begin
        pushExp(expSlot, lfsrStep(mLfsr), edgeNum + 3);
        unitTime = 10'(nextUnit);
      end
      tickEdge();
      frameTick = 1'b0;
      if (t == midAt) unitTime = 10'(midUnit);
    end
    waitValid();
  endtask

  task automatic acceptSpawn();
    bus.spawn_ready = 1'b1;
    tickEdge();
    checkOutput("validDrop", int'(bus.spawn_valid), 0);
    checkOutput("spawnCount", int'(spawnCount), expCount);
  endtask

  initial begin
    total = 0;
    bad = 0;
    hitMask = 0;
    prevV = 1'b0;
    rstN = 1'b0;
    frameTick = 1'b0;
    gameActive = 1'b0;
    unitTime = 10'd5;
    slotAlive = 8'h00;
    bus.spawn_ready = 1'b1;

    #1;
    checkOutput("resetValid", int'(bus.spawn_valid), 0);
    checkOutput("resetSlot", int'(bus.spawn_slot), 0);
    checkOutput("resetX", int'(bus.spawn_x), 0);
    checkOutput("resetY", int'(bus.spawn_y), 0);
    checkOutput("resetCount", int'(spawnCount), 0);
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    tickEdge();
    tickEdge();
    checkOutput("idleNoValid", int'(bus.spawn_valid), 0);

    vecs[0] = '{5, 8'h00, 0};
    vecs[1] = '{5, 8'h00, 0};
    vecs[2] = '{2, 8'h01, 1};
    vecs[3] = '{4, 8'h0F, 4};
    vecs[4] = '{0, 8'h7F, 7};
    vecs[5] = '{0, 8'hFE, 0};
    vecs[6] = '{7, 8'hB5, 1};
    vecs[7] = '{3, 8'hFB, 2};
    vecs[8] = '{1, 8'h3F, 6};
    unitTime = 10'(vecs[0].unit);
    gameActive = 1'b1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus((vecs[i].unit < 1) ? 1 : vecs[i].unit, vecs[i].alive, vecs[i].expSlot, 0, 0,
                    (i < 8) ? vecs[i + 1].unit : 3);
      acceptSpawn();
    end

    $display("[TB] all slots alive, then slot 4 frees");
    slotAlive = 8'hFF;
    repeat (20) driveTick();
    checkOutput("fullNoValid", int'(bus.spawn_valid), 0);
    slotAlive = 8'hEF;
    pushExp(4, mLfsr, edgeNum + 2);
    waitValid();
    acceptSpawn();
    applyStimulus(3, 8'hEF, 4, 0, 0, 4);
    acceptSpawn();

    $display("[TB] ready held low in ISSUE");
    bus.spawn_ready = 1'b0;
    applyStimulus(4, 8'h00, 0, 0, 0, 40);
    cntBefore = expCount;
    for (int k = 0; k < 10; k++) begin
      tickEdge();
      checkOutput("holdValid", int'(bus.spawn_valid), 1);
    end
    checkOutput("holdCount", int'(spawnCount), cntBefore);
    acceptSpawn();
    checkOutput("holdAccepted", int'(spawnCount), cntBefore + 1);

    $display("[TB] unit change mid interval and unit zero");
    applyStimulus(40, 8'h00, 0, 2, 10, 10);
    acceptSpawn();
    applyStimulus(10, 8'h03, 2, 0, 0, 0);
    acceptSpawn();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 8'h00, 0, 0, 0, (k < 2) ? 0 : 2);
      acceptSpawn();
    end

    $display("[TB] game inactive during ISSUE");
    bus.spawn_ready = 1'b0;
    applyStimulus(2, 8'h00, 0, 0, 0, 2);
    cntBefore = expCount;
    gameActive = 1'b0;
    tickEdge();
    checkOutput("dropValid", int'(bus.spawn_valid), 0);
    checkOutput("dropCount", int'(spawnCount), cntBefore);
    repeat (3) driveTick();
    bus.spawn_ready = 1'b1;
    gameActive = 1'b1;
    applyStimulus(2, 8'h00, 0, 0, 0, 2);
    acceptSpawn();

    bus.spawn_ready = 1'b0;
    applyStimulus(2, 8'h00, 0, 0, 0, 2);
    cntBefore = expCount;
    bus.spawn_ready = 1'b1;
    gameActive = 1'b0;
    tickEdge();
    checkOutput("simValid", int'(bus.spawn_valid), 0);
    checkOutput("simCount", int'(spawnCount), cntBefore + 1);
    gameActive = 1'b1;
    applyStimulus(2, 8'h00, 0, 0, 0, 2);
    acceptSpawn();

    $display("[TB] reset during ISSUE");
    bus.spawn_ready = 1'b0;
    applyStimulus(2, 8'h00, 0, 0, 0, 0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rstValid", int'(bus.spawn_valid), 0);
    checkOutput("rstSlot", int'(bus.spawn_slot), 0);
    checkOutput("rstX", int'(bus.spawn_x), 0);
    checkOutput("rstY", int'(bus.spawn_y), 0);
    checkOutput("rstCount", int'(spawnCount), 0);
    gameActive = 1'b0;
    tickEdge();
    tickEdge();
    rstN = 1'b1;
    repeat (3) tickEdge();
    checkOutput("rstIdleValid", int'(bus.spawn_valid), 0);

    $display("[TB] saturation run");
    bus.spawn_ready = 1'b1;
    unitTime = 10'd0;
    gameActive = 1'b1;
    for (int k = 0; k < 1100; k++) begin
      applyStimulus(1, 8'((1 << (k % 8)) - 1), k % 8, 0, 0, 0);
      acceptSpawn();
    end
    checkOutput("satCount", int'(spawnCount), 1023);
    checkOutput("pointCover", hitMask, 15);
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
